// File: rtl/regfile_16x32_sb_if.sv
// ============================================================================
// Module      : regfile_16x32_sb_if
// Description : Read, issue and write-back signal bundle between decode and
//               the 16x32 register file with pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_16x32_sb_if;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        iss_valid;
    logic [3:0]  iss_rd;
    logic        iss_ready;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    modport master (
        output rs1_addr, rs2_addr, iss_valid, iss_rd, wb_en, wb_addr, wb_data,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, iss_ready
    );

    modport slave (
        input  rs1_addr, rs2_addr, iss_valid, iss_rd, wb_en, wb_addr, wb_data,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, iss_ready
    );
endinterface

`default_nettype wire

// File: rtl/regfile_16x32_sb.sv
// ============================================================================
// Module      : regfile_16x32_sb
// Description : 16x32 register file (x0 hard-wired to zero) with optional
//               write-back forwarding and per-register pending-write counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_16x32_sb #(
    parameter int BYPASS = 1,
    parameter int CNT_W  = 2
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    regfile_16x32_sb_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam bit               c_bypass  = (BYPASS != 0);

    // x0 has no storage; the views below present it as a constant zero entry.
    logic [31:0]      r_regs    [1:15];
    logic [CNT_W-1:0] r_cnt     [1:15];
    logic [31:0]      w_reg_view[16];
    logic [CNT_W-1:0] w_cnt_view[16];
    logic             w_we      [1:15];
    logic [CNT_W-1:0] w_cnt_nxt [1:15];
    logic             w_inc;
    logic             w_dec;

    always_comb begin
        w_reg_view[0] = '0;
        w_cnt_view[0] = '0;
        for (int k = 1; k < 16; k++) begin
            w_reg_view[k] = r_regs[k];
            w_cnt_view[k] = r_cnt[k];
        end
    end

    // A saturated counter refuses the issue; an empty one ignores the write-back.
    always_comb begin
        w_inc = 1'b0;
        w_dec = 1'b0;
        for (int k = 1; k < 16; k++) begin
            w_we[k]      = bus.wb_en && (bus.wb_addr == 4'(k));
            w_inc        = bus.iss_valid && (bus.iss_rd == 4'(k)) && (r_cnt[k] != c_cnt_max);
            w_dec        = w_we[k] && (r_cnt[k] != '0);
            w_cnt_nxt[k] = r_cnt[k];
            if (w_inc && !w_dec) begin
                w_cnt_nxt[k] = r_cnt[k] + 1'b1;
            end else if (w_dec && !w_inc) begin
                w_cnt_nxt[k] = r_cnt[k] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < 16; k++) begin
                r_regs[k] <= '0;
                r_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 1; k < 16; k++) begin
                if (w_we[k]) begin
                    r_regs[k] <= bus.wb_data;
                end
                r_cnt[k] <= w_cnt_nxt[k];
            end
        end
    end

    assign bus.rs1_data = (c_bypass && bus.wb_en && (bus.wb_addr == bus.rs1_addr) && (bus.rs1_addr != 4'd0))
                          ? bus.wb_data : w_reg_view[bus.rs1_addr];
    assign bus.rs2_data = (c_bypass && bus.wb_en && (bus.wb_addr == bus.rs2_addr) && (bus.rs2_addr != 4'd0))
                          ? bus.wb_data : w_reg_view[bus.rs2_addr];

    assign bus.rs1_busy  = (bus.rs1_addr != 4'd0) && (w_cnt_view[bus.rs1_addr] != '0);
    assign bus.rs2_busy  = (bus.rs2_addr != 4'd0) && (w_cnt_view[bus.rs2_addr] != '0);
    assign bus.iss_ready = (bus.iss_rd == 4'd0) || (w_cnt_view[bus.iss_rd] != c_cnt_max);

endmodule

`default_nettype wire

// File: tb/tb_regfile_16x32_sb.sv
// ============================================================================
// Module      : tb_regfile_16x32_sb
// Description : Scoreboard bench for regfile_16x32_sb, forwarding and
//               non-forwarding instances driven side by side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_16x32_sb;

    localparam int CNT_W = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d1n;
        logic [31:0] d2n;
        logic        b1;
        logic        b2;
        logic        rdy;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_16x32_sb_if bus1();
    regfile_16x32_sb_if bus0();

    assign bus0.rs1_addr  = bus1.rs1_addr;
    assign bus0.rs2_addr  = bus1.rs2_addr;
    assign bus0.iss_valid = bus1.iss_valid;
    assign bus0.iss_rd    = bus1.iss_rd;
    assign bus0.wb_en     = bus1.wb_en;
    assign bus0.wb_addr   = bus1.wb_addr;
    assign bus0.wb_data   = bus1.wb_data;

    regfile_16x32_sb #(.BYPASS(1), .CNT_W(CNT_W)) dut_byp (.clk(clk), .rst_n(rst_n), .bus(bus1));
    regfile_16x32_sb #(.BYPASS(0), .CNT_W(CNT_W)) dut_nob (.clk(clk), .rst_n(rst_n), .bus(bus0));

    exp_t        exp_q[$];
    int unsigned m_regs[16];
    int          m_cnt[16];
    int          n_checks = 0;
    int          n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: the register file presents a fresh response every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rs1_data",     bus1.rs1_data,           e.d1);
            check("rs2_data",     bus1.rs2_data,           e.d2);
            check("rs1_data_nob", bus0.rs1_data,           e.d1n);
            check("rs2_data_nob", bus0.rs2_data,           e.d2n);
            check("rs1_busy",     {31'd0, bus1.rs1_busy},  {31'd0, e.b1});
            check("rs2_busy",     {31'd0, bus1.rs2_busy},  {31'd0, e.b2});
            check("iss_ready",    {31'd0, bus1.iss_ready}, {31'd0, e.rdy});
            check("iss_ready_nob",{31'd0, bus0.iss_ready}, {31'd0, e.rdy});
        end
    end

    // Applies one cycle of stimulus, queues the expected response and
    // advances the reference model to the state after the next clock edge.
    task automatic drive(input logic [3:0] a1, input logic [3:0] a2,
                         input logic iv, input logic [3:0] rd,
                         input logic we, input logic [3:0] wa, input logic [31:0] wd);
        exp_t e;
        bit   acc;
        bit   dec;
        bus1.rs1_addr  = a1;
        bus1.rs2_addr  = a2;
        bus1.iss_valid = iv;
        bus1.iss_rd    = rd;
        bus1.wb_en     = we;
        bus1.wb_addr   = wa;
        bus1.wb_data   = wd;
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) begin
                m_regs[k] = 0;
                m_cnt[k]  = 0;
            end
        end
        e.d1n = (a1 == 0) ? 32'd0 : m_regs[a1];
        e.d2n = (a2 == 0) ? 32'd0 : m_regs[a2];
        e.d1  = (we && wa == a1 && a1 != 0) ? wd : e.d1n;
        e.d2  = (we && wa == a2 && a2 != 0) ? wd : e.d2n;
        e.b1  = (a1 != 0) && (m_cnt[a1] > 0);
        e.b2  = (a2 != 0) && (m_cnt[a2] > 0);
        e.rdy = (rd == 0) || (m_cnt[rd] < MAXC);
        exp_q.push_back(e);
        if (rst_n) begin
            acc = iv && e.rdy && (rd != 0);
            dec = we && (wa != 0) && (m_cnt[wa] > 0);
            if (acc) m_cnt[rd] = m_cnt[rd] + 1;
            if (dec) m_cnt[wa] = m_cnt[wa] - 1;
            if (we && wa != 0) m_regs[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] a1, input logic [3:0] a2);
        drive(a1, a2, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rr;
        logic [3:0]  rw;
        logic [31:0] rd32;
        bus1.rs1_addr  = '0;
        bus1.rs2_addr  = '0;
        bus1.iss_valid = 1'b0;
        bus1.iss_rd    = '0;
        bus1.wb_en     = 1'b0;
        bus1.wb_addr   = '0;
        bus1.wb_data   = '0;
        @(posedge clk);
        #1;

        // Reset state across every index.
        idle(4'd3, 4'd9);
        rst_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rr = 4'(k);
            drive(rr, 4'(15 - k), 1'b0, rr, 1'b0, 4'd0, 32'd0);
        end

        // Plain write then read; x0 write ignored.
        drive(4'd5, 4'd0, 1'b0, 4'd0, 1'b1, 4'd5, 32'hDEADBEEF);
        idle(4'd5, 4'd5);
        drive(4'd0, 4'd5, 1'b0, 4'd0, 1'b1, 4'd0, 32'h00001234);
        idle(4'd0, 4'd0);

        // Same-cycle forwarding on read port 2.
        drive(4'd0, 4'd7, 1'b0, 4'd0, 1'b1, 4'd7, 32'hA5A5A5A5);
        idle(4'd7, 4'd7);

        // Counter saturation at 3, then drain with one extra write-back.
        for (int k = 0; k < 4; k++) drive(4'd3, 4'd0, 1'b1, 4'd3, 1'b0, 4'd0, 32'd0);
        for (int k = 0; k < 4; k++) drive(4'd3, 4'd3, 1'b0, 4'd3, 1'b1, 4'd3, 32'h3000_0000 + 32'(k));
        idle(4'd3, 4'd3);

        // Same-cycle issue and write-back to a register with count 1.
        drive(4'd9, 4'd0, 1'b1, 4'd9, 1'b0, 4'd0, 32'd0);
        drive(4'd9, 4'd9, 1'b1, 4'd9, 1'b1, 4'd9, 32'h0909_0909);
        idle(4'd9, 4'd9);

        // Asynchronous reset between two clock edges with writes pending.
        drive(4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd4, 32'h4444_4444);
        drive(4'd4, 4'd0, 1'b1, 4'd4, 1'b0, 4'd0, 32'd0);
        drive(4'd4, 4'd0, 1'b1, 4'd4, 1'b0, 4'd0, 32'd0);
        idle(4'd4, 4'd4);
        rst_n = 1'b0;
        drive(4'd4, 4'd4, 1'b0, 4'd4, 1'b0, 4'd0, 32'd0);
        rst_n = 1'b1;
        drive(4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'd4, 32'h0404_0404);
        idle(4'd4, 4'd4);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 1500; n++) begin
            ra   = 4'($urandom_range(0, 15));
            rb   = 4'($urandom_range(0, 15));
            rr   = 4'($urandom_range(0, 15));
            rw   = 4'($urandom_range(0, 15));
            rd32 = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                drive(ra, rb, 1'($urandom_range(0, 1)), rr, 1'b0, rw, rd32);
                rst_n = 1'b1;
            end else begin
                drive(ra, rb, 1'($urandom_range(0, 1)), rr, 1'($urandom_range(0, 1)), rw, rd32);
            end
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errs++;
            $display("FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
